key_sw_sampler: RTL and testbench
=================================

# key_sw_sampler

Input-conditioning stage that sits directly upstream of `bpnetwork`. It synchronises the raw active-low push-button `key` and the 9-bit switch bank `sw`, debounces the button, and on each qualified press issues a single-cycle `start` pulse with a frozen copy of the switches. It then locks out further presses until the network signals completion, so the network never sees a second request mid-run or a bounce-induced retrigger.

## Interface
Parameters:
- `SW_W`, 9: switch bus width.
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable synchronised cycles required to accept a level change (20 ms at 50 MHz).
- `CNT_W`, 20: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- `clk` in 1: system clock; the block uses one clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `key` in 1: raw push-button, active-low (pressed = 0), asynchronous to `clk`.
- `sw` in SW_W: raw switch bank, asynchronous to `clk`.
- `finish` in 1: completion flag from `bpnetwork`; level or pulse.
- `start` out 1: one-cycle request pulse; drives `bpnetwork` `en`.
- `sw_latched` out SW_W: switch snapshot, valid from the `start` cycle onward and held until the next `start`.
- `busy` out 1: high from the `start` cycle until accepted completion.

## Operation
- `key` and every `sw` bit pass through a 2-flop synchroniser. Internally, `key_s = ~key` after the synchroniser, so a press reads as 1.
- The debounce counter resets to 0 on every cycle where `key_s` differs from the previous synchronised sample. It saturates at DEBOUNCE_CYCLES.
- The stable-press condition holds when the counter equals DEBOUNCE_CYCLES and `key_s` = 1. The stable-release condition is the same with `key_s` = 0.
- `finish` is edge-detected: only a 0→1 transition counts as completion.
- FSM states and transitions:
  - IDLE → PRESS when `key_s` = 1.
  - PRESS → ISSUE on stable press.
  - PRESS → IDLE if `key_s` returns to 0 before the count completes.
  - ISSUE lasts exactly one cycle. It asserts `start` and captures the synchronised `sw` into `sw_latched`, then goes to WAIT_DONE.
  - WAIT_DONE → RELEASE on a `finish` rising edge. All key activity is ignored in this state.
  - RELEASE → IDLE on stable release. A press still held after completion therefore never retriggers.
- `busy` is 1 in ISSUE and WAIT_DONE, and 0 otherwise.

## Timing
- Reset values: `start` = 0, `busy` = 0, `sw_latched` = 0, FSM = IDLE, counter = 0, synchroniser flops = released level (key = 1, sw = 0).
- Latency from a clean `key` falling edge to `start`: 2 synchroniser cycles + DEBOUNCE_CYCLES + 1 registered cycle.
- `start` and `busy` are registered outputs. `start` is never high on two consecutive cycles.
- `sw_latched` changes only on the clock edge that raises `start`. Switch changes at any other time have no effect on it.
- `finish` already high when `busy` rises does not complete the run; a fresh 0→1 edge is required.
- A `finish` edge in the same cycle as ISSUE is ignored. Completion is sampled only in WAIT_DONE.
- Bounce inside RELEASE restarts the release count; the FSM stays in RELEASE.
- Asserting `rst_n` low in any state immediately drops `start` and `busy` and returns the block to IDLE.

## Structure
- Shared header `bp_defines.vh` holds:
  - the FSM state encodings (IDLE=0, PRESS=1, ISSUE=2, WAIT_DONE=3, RELEASE=4; 3 bits);
  - the default `SW_W`;
  - the default `DEBOUNCE_CYCLES`.
- One sub-module, `sync_2ff`, parameterised by width and reset value. It is instantiated twice: once for `key` (reset 1) and once for `sw` (reset 0).
- `top` replaces its `~key` feed with this block:
  - `start` drives `bpnetwork.en`;
  - `sw_latched` drives `bpnetwork.sw`;
  - `bpnetwork.finish` feeds `finish`.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset: hold `rst_n`=0 with `key`=0 and `sw`=9'h1FF → `start`=0, `busy`=0, `sw_latched`=0. Release reset with `key`=1 → no `start`.
- Clean press: `sw`=9'h0A5, drop `key` and hold → exactly one `start` pulse 7 cycles later, `sw_latched`=9'h0A5, `busy`=1. Change `sw` to 9'h1FF → `sw_latched` stays 9'h0A5.
- Bounce: toggle `key` every 2 cycles for 20 cycles, then return it high → no `start`, and FSM back in IDLE.
- Lockout: while `busy`, release and re-press `key` three times with 10 stable cycles each → no `start`. Pulse `finish` → `busy`=0 the next cycle.
- Held key / finish level: keep `key` low through a `finish` pulse → no second `start`. Pre-hold `finish`=1 before a press → `busy` stays 1 until `finish` falls and rises again.
- Mid-run reset: assert `rst_n`=0 during WAIT_DONE → `busy` and `start` are 0 asynchronously. After release, a new press yields a normal `start`.

Source files
------------

// File: rtl/key_sw_sampler_pkg.sv
// Shared types and defaults for the key/switch input-conditioning stage.
package key_sw_sampler_pkg;

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StPress    = 3'd1,
      StIssue    = 3'd2,
      StWaitDone = 3'd3,
      StRelease  = 3'd4
   } state_t;

   localparam int unsigned SwWDefault            = 9;
   localparam int unsigned DebounceCyclesDefault = 1_000_000;
   localparam int unsigned CntWDefault           = 20;

endpackage

// File: rtl/key_sw_sampler_sync_2ff.sv
// Two-flop synchroniser with a configurable reset level.
module key_sw_sampler_sync_2ff #(
   parameter int unsigned        Width    = 1,
   parameter logic [Width-1:0]   ResetVal = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [Width-1:0] d,
   output logic [Width-1:0] q
);

   logic [Width-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= ResetVal;
         q    <= ResetVal;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/key_sw_sampler.sv
// Synchronises key/switches, debounces the key and issues one start pulse per press,
// locking out further presses until the downstream network reports completion.
module key_sw_sampler
   import key_sw_sampler_pkg::*;
#(
   parameter int unsigned SW_W            = SwWDefault,
   parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault,
   parameter int unsigned CNT_W           = CntWDefault
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            key,
   input  logic [SW_W-1:0] sw,
   input  logic            finish,
   output logic            start,
   output logic [SW_W-1:0] sw_latched,
   output logic            busy
);

   localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES);

   logic            key_sync;
   logic            key_s;
   logic            key_s_prev;
   logic [SW_W-1:0] sw_s;
   logic [CNT_W-1:0] cnt;
   logic            finish_prev;
   logic            stable;
   logic            stable_press;
   logic            stable_release;
   logic            finish_rise;
   state_t          state;

   key_sw_sampler_sync_2ff #(
      .Width    (1),
      .ResetVal (1'b1)
   ) u_key_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (key),
      .q     (key_sync)
   );

   key_sw_sampler_sync_2ff #(
      .Width    (SW_W),
      .ResetVal ({SW_W{1'b0}})
   ) u_sw_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (sw),
      .q     (sw_s)
   );

   assign key_s          = ~key_sync;
   assign stable         = (cnt == CntMax);
   assign stable_press   = stable & key_s;
   assign stable_release = stable & ~key_s;
   assign finish_rise    = finish & ~finish_prev;

   // Any change of the synchronised key restarts the stability count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_s_prev  <= 1'b0;
         finish_prev <= 1'b0;
         cnt         <= '0;
      end else begin
         key_s_prev  <= key_s;
         finish_prev <= finish;
         if (key_s != key_s_prev) begin
            cnt <= '0;
         end else if (!stable) begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= StIdle;
         start      <= 1'b0;
         busy       <= 1'b0;
         sw_latched <= '0;
      end else begin
         start <= 1'b0;
         case (state)
            StIdle: begin
               if (key_s) state <= StPress;
            end
            StPress: begin
               if (!key_s) begin
                  state <= StIdle;
               end else if (stable_press) begin
                  state      <= StIssue;
                  start      <= 1'b1;
                  busy       <= 1'b1;
                  sw_latched <= sw_s;
               end
            end
            StIssue: begin
               state <= StWaitDone;
            end
            StWaitDone: begin
               // Key activity is deliberately ignored until completion.
               if (finish_rise) begin
                  state <= StRelease;
                  busy  <= 1'b0;
               end
            end
            StRelease: begin
               if (stable_release) state <= StIdle;
            end
            default: begin
               state <= StIdle;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_key_sw_sampler.sv
// Directed bench for key_sw_sampler with a short debounce window.
module tb_key_sw_sampler;
   import key_sw_sampler_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       key;
   logic [8:0] sw;
   logic       finish;
   logic       start;
   logic [8:0] sw_latched;
   logic       busy;

   int         n_vec = 0;
   int         n_err = 0;
   logic [8:0] exp_lat = 9'h000;

   typedef struct {
      logic       key;
      logic [8:0] sw;
      logic       fin;
      logic       e_start;
      logic       e_busy;
      logic [8:0] e_lat;
   } vec_t;

   vec_t tbl [10];

   key_sw_sampler #(
      .SW_W            (9),
      .DEBOUNCE_CYCLES (4),
      .CNT_W           (3)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key        (key),
      .sw         (sw),
      .finish     (finish),
      .start      (start),
      .sw_latched (sw_latched),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic es, input logic eb, input logic [8:0] el);
      n_vec++;
      if (start !== es) begin
         n_err++;
         $display("FAIL %s: start got %b want %b", name, start, es);
      end
      if (busy !== eb) begin
         n_err++;
         $display("FAIL %s: busy got %b want %b", name, busy, eb);
      end
      if (sw_latched !== el) begin
         n_err++;
         $display("FAIL %s: sw_latched got %h want %h", name, sw_latched, el);
      end
   endtask

   task automatic check_idle(input string name);
      n_vec++;
      if (dut.state !== StIdle) begin
         n_err++;
         $display("FAIL %s: state got %0d want %0d", name, dut.state, StIdle);
      end
   endtask

   // Drive inputs mid-cycle, then sample just after the next rising edge.
   task automatic cyc(input logic k, input logic [8:0] s, input logic f);
      @(negedge clk);
      key    = k;
      sw     = s;
      finish = f;
      @(posedge clk);
      #1;
   endtask

   // Key captured on edge 1; start expected on edge 8 (2 sync + 4 stable + 1 registered).
   task automatic press(input string name, input logic [8:0] s, input logic f);
      for (int i = 1; i <= 8; i++) begin
         cyc(1'b0, s, f);
         if (i == 8) begin
            exp_lat = s;
            check($sformatf("%s_start", name), 1'b1, 1'b1, exp_lat);
         end else begin
            check($sformatf("%s_pre[%0d]", name, i), 1'b0, 1'b0, exp_lat);
         end
      end
   endtask

   task automatic release_key(input string name, input logic [8:0] s);
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, s, 1'b0);
         check($sformatf("%s_rel[%0d]", name, i), 1'b0, 1'b0, exp_lat);
      end
      check_idle($sformatf("%s_idle", name));
   endtask

   initial begin
      for (int i = 0; i < 7; i++) tbl[i] = '{1'b0, 9'h0A5, 1'b0, 1'b0, 1'b0, 9'h000};
      tbl[7] = '{1'b0, 9'h0A5, 1'b0, 1'b1, 1'b1, 9'h0A5};
      tbl[8] = '{1'b0, 9'h1FF, 1'b0, 1'b0, 1'b1, 9'h0A5};
      tbl[9] = '{1'b0, 9'h1FF, 1'b0, 1'b0, 1'b1, 9'h0A5};

      // Reset with pressed key and all switches high.
      rst_n  = 1'b0;
      key    = 1'b0;
      sw     = 9'h1FF;
      finish = 1'b0;
      #1;
      check("reset_t0", 1'b0, 1'b0, 9'h000);
      repeat (3) @(posedge clk);
      #1;
      check("reset_held", 1'b0, 1'b0, 9'h000);
      check_idle("reset_state");
      @(negedge clk);
      key   = 1'b1;
      sw    = 9'h000;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cyc(1'b1, 9'h000, 1'b0);
         check($sformatf("post_reset[%0d]", i), 1'b0, 1'b0, 9'h000);
      end

      // Clean press, then switch change after capture.
      for (int i = 0; i < 10; i++) begin
         cyc(tbl[i].key, tbl[i].sw, tbl[i].fin);
         check($sformatf("clean[%0d]", i), tbl[i].e_start, tbl[i].e_busy, tbl[i].e_lat);
      end
      exp_lat = 9'h0A5;

      // Lockout: release and re-press while busy.
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 9'h1FF, 1'b0);
            check($sformatf("lock_up[%0d][%0d]", r, i), 1'b0, 1'b1, exp_lat);
         end
         for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 9'h1FF, 1'b0);
            check($sformatf("lock_dn[%0d][%0d]", r, i), 1'b0, 1'b1, exp_lat);
         end
      end

      // Finish pulse with key still held: completes, no retrigger.
      cyc(1'b0, 9'h1FF, 1'b1);
      check("finish_pulse", 1'b0, 1'b0, exp_lat);
      for (int i = 0; i < 20; i++) begin
         cyc(1'b0, 9'h1FF, 1'b0);
         check($sformatf("held[%0d]", i), 1'b0, 1'b0, exp_lat);
      end
      release_key("held", 9'h1FF);

      // Bounce: toggle every 2 cycles.
      for (int i = 0; i < 20; i++) begin
         cyc(((i / 2) % 2) != 0, 9'h000, 1'b0);
         check($sformatf("bounce[%0d]", i), 1'b0, 1'b0, exp_lat);
      end
      release_key("bounce", 9'h000);

      // Finish edge coinciding with ISSUE is ignored.
      press("issue_fin", 9'h0F0, 1'b0);
      cyc(1'b0, 9'h0F0, 1'b1);
      check("issue_fin_edge", 1'b0, 1'b1, exp_lat);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 9'h0F0, 1'b1);
         check($sformatf("issue_fin_hi[%0d]", i), 1'b0, 1'b1, exp_lat);
      end
      cyc(1'b0, 9'h0F0, 1'b0);
      check("issue_fin_lo", 1'b0, 1'b1, exp_lat);
      cyc(1'b0, 9'h0F0, 1'b1);
      check("issue_fin_rise", 1'b0, 1'b0, exp_lat);
      release_key("issue_fin", 9'h0F0);

      // Finish already high before the press.
      for (int i = 0; i < 2; i++) begin
         cyc(1'b1, 9'h13C, 1'b1);
         check($sformatf("prehold_idle[%0d]", i), 1'b0, 1'b0, exp_lat);
      end
      press("prehold", 9'h13C, 1'b1);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 9'h13C, 1'b1);
         check($sformatf("prehold_hi[%0d]", i), 1'b0, 1'b1, exp_lat);
      end
      cyc(1'b0, 9'h13C, 1'b0);
      check("prehold_lo", 1'b0, 1'b1, exp_lat);
      cyc(1'b0, 9'h13C, 1'b1);
      check("prehold_rise", 1'b0, 1'b0, exp_lat);
      release_key("prehold", 9'h13C);

      // Mid-run asynchronous reset.
      press("midrun", 9'h155, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 9'h155, 1'b0);
         check($sformatf("midrun_wait[%0d]", i), 1'b0, 1'b1, exp_lat);
      end
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      exp_lat = 9'h000;
      check("midrun_async", 1'b0, 1'b0, exp_lat);
      check_idle("midrun_state");
      key = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      release_key("after_rst", 9'h0AA);
      press("after_rst", 9'h0AA, 1'b0);
      cyc(1'b0, 9'h0AA, 1'b0);
      check("after_rst_single", 1'b0, 1'b1, exp_lat);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
